// File: rtl/gcd_feeder_if.sv
// Operand-in, result-out and core-side signals of the GCD feeder.
// The slave modport is the feeder's view; master is the surrounding environment.
interface gcd_feeder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             _in_valid;
   logic             _in_ready;
   logic [WIDTH-1:0] _in_num0;
   logic [WIDTH-1:0] _in_num1;
   logic             _out_valid;
   logic             _out_ready;
   logic [WIDTH-1:0] _out_greatest;
   logic             _out_timeout;
   logic             _gcd_start;
   logic [WIDTH-1:0] _gcd_num0;
   logic [WIDTH-1:0] _gcd_num1;
   logic [WIDTH-1:0] _gcd_greatest;
   logic             _gcd_success;

   modport slave (
      input  _in_valid, _in_num0, _in_num1, _out_ready, _gcd_greatest, _gcd_success,
      output _in_ready, _out_valid, _out_greatest, _out_timeout, _gcd_start, _gcd_num0, _gcd_num1
   );

   modport master (
      output _in_valid, _in_num0, _in_num1, _out_ready, _gcd_greatest, _gcd_success,
      input  _in_ready, _out_valid, _out_greatest, _out_timeout, _gcd_start, _gcd_num0, _gcd_num1
   );
endinterface

// File: rtl/gcd_feeder.sv
// Buffers operand pairs, runs them one at a time through the GCD core with a
// timeout, and resolves pairs containing a zero operand without the core.
module gcd_feeder #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input logic        _clock,
   input logic        _reset,
   gcd_feeder_if.slave bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef struct packed {
      logic [WIDTH-1:0] num0;
      logic [WIDTH-1:0] num1;
   } pair_t;

   typedef enum logic [1:0] {IDLE, RUN, RESULT} state_t;

   state_t           state, state_next;
   pair_t            mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic [CW-1:0]    cnt, cnt_next;
   logic [WIDTH-1:0] num0_q, num1_q, num0_next, num1_next;
   logic [WIDTH-1:0] greatest_q, greatest_next;
   logic             timeout_q, timeout_next;
   logic             start_q, start_next;
   logic             valid_q, valid_next;
   logic             full, empty, push, pop;
   pair_t            head;

   // Ready depends only on registered occupancy, never on a same-cycle pop.
   assign full          = (count == (AW+1)'(DEPTH));
   assign empty         = (count == '0);
   assign bus._in_ready = !full && !_reset;
   assign push          = bus._in_valid && bus._in_ready;
   assign pop           = (state == IDLE) && !empty;
   assign head          = mem[rd_ptr];

   // Storage carries no reset; occupancy tracking below decides what is live.
   always_ff @(posedge _clock) begin
      if (push) mem[wr_ptr] <= '{num0: bus._in_num0, num1: bus._in_num1};
   end

   always_ff @(posedge _clock) begin
      if (_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge _clock) begin
      if (_reset) begin
         state      <= IDLE;
         cnt        <= '0;
         num0_q     <= '0;
         num1_q     <= '0;
         greatest_q <= '0;
         timeout_q  <= 1'b0;
         start_q    <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         num0_q     <= num0_next;
         num1_q     <= num1_next;
         greatest_q <= greatest_next;
         timeout_q  <= timeout_next;
         start_q    <= start_next;
         valid_q    <= valid_next;
      end
   end

   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      num0_next     = num0_q;
      num1_next     = num1_q;
      greatest_next = greatest_q;
      timeout_next  = timeout_q;
      unique case (state)
         IDLE: begin
            if (pop) begin
               if ((head.num0 != '0) && (head.num1 != '0)) begin
                  num0_next  = head.num0;
                  num1_next  = head.num1;
                  cnt_next   = '0;
                  state_next = RUN;
               end else begin
                  // gcd(a,0)=a and gcd(0,0)=0, so the OR is the answer.
                  greatest_next = head.num0 | head.num1;
                  timeout_next  = 1'b0;
                  state_next    = RESULT;
               end
            end
         end
         RUN: begin
            // First RUN cycle is the core's latch cycle; its success is stale.
            if ((cnt != '0) && bus._gcd_success) begin
               greatest_next = bus._gcd_greatest;
               timeout_next  = 1'b0;
               state_next    = RESULT;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               greatest_next = '0;
               timeout_next  = 1'b1;
               state_next    = RESULT;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         RESULT: begin
            if (bus._out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      start_next = (state_next == RUN);
      valid_next = (state_next == RESULT);
   end

   assign bus._gcd_start    = start_q;
   assign bus._gcd_num0     = num0_q;
   assign bus._gcd_num1     = num1_q;
   assign bus._out_valid    = valid_q;
   assign bus._out_greatest = greatest_q;
   assign bus._out_timeout  = timeout_q;
endmodule

// File: doc/gcd_feeder.md
# gcd_feeder

Operand sequencer that sits directly upstream of the `_gcd` core. It accepts operand pairs over a valid/ready input and buffers them in a small FIFO. It issues one pair at a time to the core and holds `_start` until `_success`. It then presents each result, with a timeout flag, over a valid/ready output. Pairs with a zero operand are resolved locally and never reach the core.

## Interface
- WIDTH, 8, operand/result width (matches `_gcd` `_num0`/`_num1`/`_greatest`)
- DEPTH, 4, input FIFO entries (power of two, ≥2)
- TIMEOUT, 255, max RUN cycles waiting for `_success` before abort (≥2)

- _clock  in  1  single clock, all logic on rising edge
- _reset  in  1  synchronous, active-high
- _in_valid  in  1  operand pair offered
- _in_ready  out  1  FIFO can accept
- _in_num0  in  WIDTH  operand A
- _in_num1  in  WIDTH  operand B
- _out_valid  out  1  result held
- _out_ready  in  1  consumer accepts result
- _out_greatest  out  WIDTH  GCD result
- _out_timeout  out  1  result aborted by timeout (`_out_greatest`=0)
- _gcd_start  out  1  to core `_start`
- _gcd_num0  out  WIDTH  to core `_num0`
- _gcd_num1  out  WIDTH  to core `_num1`
- _gcd_greatest  in  WIDTH  from core `_greatest`
- _gcd_success  in  1  from core `_success`

## Operation
- Reset: FIFO empty; state IDLE; `_in_ready`=0 during reset, then 1.
- Reset: `_out_valid`=0, `_out_greatest`=0, `_out_timeout`=0, `_gcd_start`=0, `_gcd_num0/1`=0, cycle counter=0.
- FIFO push: `_in_valid & _in_ready` at an edge. `_in_ready` = !full. It is combinational from registered count and does not depend on a same-cycle pop. When full, no push occurs even if a pop happens that cycle.
- FIFO pop: only in IDLE with FIFO non-empty. The pop happens at the edge ending that IDLE cycle.
- State machine (registered):
  - IDLE: `_gcd_start`=0.
    - On pop with both operands non-zero: load `_gcd_num0/1`, clear counter, go to RUN.
    - On pop with either operand zero: load result = num0|num1, which gives gcd(a,0)=a and gcd(0,0)=0. Timeout=0; go to RESULT. The core is not touched.
  - RUN: `_gcd_start`=1; `_gcd_num0/1` stable; counter increments each cycle.
    - `_gcd_success` is ignored on the first RUN cycle (counter==0), while the core latches.
    - From counter≥1, `_gcd_success`=1 captures `_gcd_greatest` into `_out_greatest`, sets `_out_timeout`=0 and goes to RESULT.
    - If counter reaches TIMEOUT−1 with no success: `_out_greatest`=0, `_out_timeout`=1, go to RESULT.
    - Success on that same cycle wins over timeout.
  - RESULT: `_gcd_start`=0; `_out_valid`=1. Result registers are stable until `_out_valid & _out_ready`, then go to IDLE.
- `_gcd_start` is low for at least 2 cycles (RESULT+IDLE) between jobs, so the core clears `_success`.
- Results leave in FIFO order. One job is in flight at a time.
- Counter width: clog2(TIMEOUT+1). No wrap, because it saturates by leaving RUN.
- Reset mid-operation: on the next edge, everything returns to reset values. The FIFO contents, the in-flight job and any held result are discarded.

## Timing
- Input-to-core: pair pushed at edge E into empty FIFO, state IDLE. Pop at E+1; `_gcd_start`=1 during cycle after E+1.
- Core-to-output: `_gcd_success` sampled high at edge S. `_out_valid`=1 during cycle after S.
- Zero shortcut: pushed at E, `_out_valid`=1 after E+1 (2 edges after push).
- Output back-to-back: result accepted at edge A with FIFO non-empty. IDLE during the cycle after A; pop at A+1; RUN after A+1.
- Capacity with `_out_ready` held low: DEPTH+1 pairs accepted (one popped into RUN/RESULT), then `_in_ready`=0.

## Test plan
- Real `_gcd` core, push (36,24), `_out_ready`=1. Required: `_gcd_start` rises 2 edges after push and stays high until `_success`. `_out_greatest`=12 with `_out_timeout`=0 for exactly one cycle. `_gcd_start` is low the cycle after success.
- Push (0,17), (17,0), (0,0). Required: results 17, 17, 0 in order. `_gcd_start` never asserts. The first `_out_valid` comes 2 edges after its push.
- `_out_ready`=0, push 6 pairs back-to-back. Required: exactly 5 accepted, then `_in_ready`=0. Release `_out_ready`: results emerge in push order, each held stable while waiting.
- Core stub with `_success` tied 0, TIMEOUT=10, push (9,6). Required: `_gcd_start` high exactly 10 cycles. Result `_out_greatest`=0, `_out_timeout`=1. The next job proceeds normally.
- Stub asserting `_success` on the first RUN cycle only with `_greatest`=99. Required: it is ignored and the feeder waits for a later success.
- Assert `_reset` for one cycle while in RUN with 3 pairs queued. Required: the next cycle shows `_gcd_start`=0, `_out_valid`=0 and `_in_ready`=1. No stale result is ever emitted.
